// File: rtl/fp_operand_loader.sv
// fp_operand_loader: assembles two binary32 operands from a byte stream and presents them as a valid/ready pair
module fp_operand_loader #(
  parameter int MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        clear,
  input  logic        op_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        op_valid,
  output logic [1:0]  a_class,
  output logic [1:0]  b_class,
  output logic [2:0]  byte_idx,
  output logic        overrun
);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;
  state_t state;
  logic [31:0] sh_a, sh_b, sh_a_nxt, sh_b_nxt;
  function automatic logic [1:0] classify(input logic [31:0] x);
    return (x[30:23] == 8'hff) ? ((x[22:0] != 23'd0) ? 2'b11 : 2'b10) :
           (x[30:23] == 8'h00) ? 2'b01 : 2'b00;
  endfunction
  assign sh_a_nxt = (MSB_FIRST != 0) ? {sh_a[23:0], byte_in} : {byte_in, sh_a[31:8]};
  assign sh_b_nxt = (MSB_FIRST != 0) ? {sh_b[23:0], byte_in} : {byte_in, sh_b[31:8]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD_A;
      sh_a     <= '0;
      sh_b     <= '0;
      a        <= '0;
      b        <= '0;
      a_class  <= 2'b01;
      b_class  <= 2'b01;
      op_valid <= 1'b0;
      byte_idx <= '0;
      overrun  <= 1'b0;
    end else if (clear) begin
      state    <= LOAD_A;
      sh_a     <= '0;
      sh_b     <= '0;
      op_valid <= 1'b0;
      byte_idx <= '0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (byte_valid) begin
          sh_a     <= sh_a_nxt;
          byte_idx <= byte_idx + 3'd1;
          if (byte_idx == 3'd3) state <= LOAD_B;
        end
        LOAD_B: if (byte_valid) begin
          sh_b     <= sh_b_nxt;
          byte_idx <= byte_idx + 3'd1;
          if (byte_idx == 3'd7) begin
            state    <= HOLD;
            a        <= sh_a;
            b        <= sh_b_nxt;
            a_class  <= classify(sh_a);
            b_class  <= classify(sh_b_nxt);
            op_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (byte_valid) overrun <= 1'b1;
          if (op_ready) begin
            state    <= LOAD_A;
            op_valid <= 1'b0;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_operand_loader.sv
// tb_fp_operand_loader: randomized and directed check of both byte orders against a behavioural model
module tb_fp_operand_loader;
  logic clk = 0, rst = 1, clear = 0, byte_valid = 0, op_ready = 0;
  logic [7:0] byte_in = 0;
  logic [31:0] a1, b1, a0, b0;
  logic [1:0] ac1, bc1, ac0, bc0;
  logic [2:0] idx1, idx0;
  logic ov1, ov0, v1, v0;
  int checks = 0, errors = 0;
  bit run = 0;
  always #5 clk = ~clk;
  fp_operand_loader #(.MSB_FIRST(1)) u1 (.clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .clear(clear), .op_ready(op_ready), .a(a1), .b(b1), .op_valid(v1), .a_class(ac1), .b_class(bc1),
    .byte_idx(idx1), .overrun(ov1));
  fp_operand_loader #(.MSB_FIRST(0)) u0 (.clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .clear(clear), .op_ready(op_ready), .a(a0), .b(b0), .op_valid(v0), .a_class(ac0), .b_class(bc0),
    .byte_idx(idx0), .overrun(ov0));
  // behavioural model: a list of collected bytes and a pending flag
  logic [7:0] bytes [8];
  int cnt;
  bit pend, ovr;
  logic [31:0] ma1, mb1, ma0, mb0;
  function automatic logic [1:0] cls(input logic [31:0] x);
    if (x[30:23] == 8'hff) return (x[22:0] != 0) ? 2'd3 : 2'd2;
    if (x[30:23] == 8'h00) return 2'd1;
    return 2'd0;
  endfunction
  task automatic model_step();
    if (rst) begin
      cnt = 0; pend = 0; ovr = 0; ma1 = 0; mb1 = 0; ma0 = 0; mb0 = 0;
    end else if (clear) begin
      cnt = 0; pend = 0; ovr = 0;
    end else if (pend) begin
      if (byte_valid) ovr = 1;
      if (op_ready) pend = 0;
    end else if (byte_valid) begin
      bytes[cnt] = byte_in;
      cnt++;
      if (cnt == 8) begin
        ma1 = {bytes[0], bytes[1], bytes[2], bytes[3]};
        mb1 = {bytes[4], bytes[5], bytes[6], bytes[7]};
        ma0 = {bytes[3], bytes[2], bytes[1], bytes[0]};
        mb0 = {bytes[7], bytes[6], bytes[5], bytes[4]};
        pend = 1;
        cnt = 0;
      end
    end
  endtask
  always @(posedge clk) model_step();
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (run) begin
    chk("a_msb", a1, ma1);
    chk("b_msb", b1, mb1);
    chk("a_lsb", a0, ma0);
    chk("b_lsb", b0, mb0);
    chk("acls_msb", 32'(ac1), 32'(cls(ma1)));
    chk("bcls_msb", 32'(bc1), 32'(cls(mb1)));
    chk("acls_lsb", 32'(ac0), 32'(cls(ma0)));
    chk("bcls_lsb", 32'(bc0), 32'(cls(mb0)));
    chk("valid_msb", 32'(v1), 32'(pend));
    chk("valid_lsb", 32'(v0), 32'(pend));
    chk("idx_msb", 32'(idx1), cnt);
    chk("idx_lsb", 32'(idx0), cnt);
    chk("ovr_msb", 32'(ov1), 32'(ovr));
    chk("ovr_lsb", 32'(ov0), 32'(ovr));
  end
  task automatic drive(input logic r, input logic c, input logic v, input logic [7:0] d, input logic rd);
    @(negedge clk);
    rst = r; clear = c; byte_valid = v; byte_in = d; op_ready = rd;
  endtask
  task automatic idle();
    drive(0, 0, 0, 8'h00, 0);
  endtask
  task automatic load(input logic [63:0] w);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, w[63-8*i -: 8], 0);
    idle();
  endtask
  task automatic handshake();
    drive(0, 0, 0, 8'h00, 1);
    idle();
  endtask
  initial begin
    drive(1, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 8'h00, 0);
    idle();
    run = 1;
    chk("reset_a", a1, 32'h0);
    chk("reset_acls", 32'(ac1), 32'd1);
    chk("reset_bcls", 32'(bc0), 32'd1);
    chk("reset_valid", 32'(v1), 32'd0);
    load(64'h41700000_41A00000);
    chk("lit_a", a1, 32'h41700000);
    chk("lit_b", b1, 32'h41A00000);
    chk("lit_valid", 32'(v1), 32'd1);
    chk("lit_cls", 32'({ac1, bc1}), 32'd0);
    repeat (5) idle();
    chk("hold_a", a1, 32'h41700000);
    handshake();
    chk("hs_valid", 32'(v1), 32'd0);
    chk("hs_b", b1, 32'h41A00000);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'(i + 1), 0);
    idle();
    chk("idx5", 32'(idx1), 32'd5);
    drive(0, 1, 0, 8'h00, 0);
    idle();
    chk("idx_clr", 32'(idx1), 32'd0);
    chk("keep_a", a1, 32'h41700000);
    load({$urandom, $urandom});
    drive(0, 0, 1, 8'hAA, 0);
    drive(0, 0, 1, 8'hBB, 0);
    idle();
    chk("overrun", 32'(ov1), 32'd1);
    drive(0, 0, 1, 8'hCC, 1);
    idle();
    load(64'h7FC00000_7F800000);
    chk("nan_cls", 32'(ac1), 32'd3);
    chk("inf_cls", 32'(bc1), 32'd2);
    chk("ovr_sticky", 32'(ov1), 32'd1);
    handshake();
    load(64'h00000001_80000000);
    chk("sub_cls", 32'(ac1), 32'd1);
    chk("zero_cls", 32'(bc1), 32'd1);
    drive(0, 1, 0, 8'h00, 1);
    idle();
    chk("clr_hs_valid", 32'(v1), 32'd0);
    chk("clr_hs_a", a1, 32'h00000001);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 8'h55, 0);
    drive(1, 0, 0, 8'h00, 0);
    idle();
    chk("rst_a", a1, 32'h0);
    chk("rst_bcls", 32'(bc1), 32'd1);
    load(64'h00007041_0000A041);
    chk("lsb_a", a0, 32'h41700000);
    chk("lsb_b", b0, 32'h41A00000);
    handshake();
    drive(0, 1, 1, 8'h12, 0);
    idle();
    chk("clr_byte", 32'(idx1), 32'd0);
    repeat (800) drive($urandom_range(99) == 0, $urandom_range(39) == 0, $urandom_range(9) < 6,
                       8'($urandom), $urandom_range(9) < 3);
    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_operand_loader.md
# fp_operand_loader

Upstream feeder for the combinational single-precision adder `fp_add`. Assembles two IEEE-754 binary32 operands from a byte-serial input stream (switch bank plus debounced load button), then presents them as a stable `a`/`b` pair with a valid/ready handshake. It also reports a per-operand class code so the display path can flag special values before the sum is shown.

## Interface
- `MSB_FIRST`, default 1: byte order within each operand. 1 means the first byte is bits [31:24]; 0 means the first byte is bits [7:0].
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `byte_in`  in  8  operand byte (switches).
- `byte_valid`  in  1  single-cycle strobe; `byte_in` is sampled on the edge where this is 1. It is already debounced and edge-detected.
- `clear`  in  1  synchronous abort; discards any partially loaded operands.
- `op_ready`  in  1  downstream accepts the pair.
- `a`  out  32  operand A to `fp_add`.
- `b`  out  32  operand B to `fp_add`.
- `op_valid`  out  1  `a`/`b` hold a new, complete pair.
- `a_class`  out  2  class of `a`: 00 normal, 01 zero/subnormal, 10 infinity, 11 NaN.
- `b_class`  out  2  class of `b`, same encoding.
- `byte_idx`  out  3  bytes accepted in the current load, 0–7.
- `overrun`  out  1  sticky flag: a byte arrived while a pair was pending.

## Operation
- Three states:
  - LOAD_A: bytes 0–3.
  - LOAD_B: bytes 4–7.
  - HOLD: pair pending.
- Reset state is LOAD_A.
- LOAD_A: each accepted byte shifts into `sh_a` and increments `byte_idx`.
  - `MSB_FIRST`=1: `sh_a <= {sh_a[23:0], byte_in}`.
  - `MSB_FIRST`=0: `sh_a <= {byte_in, sh_a[31:8]}`.
  - The 4th byte moves the block to LOAD_B.
- LOAD_B: same shifting into `sh_b`.
  - The 4th byte (8th overall) moves the block to HOLD.
  - On that same edge: `a <= sh_a`, `b <= sh_b` (the B value includes the byte arriving now), class codes update, `op_valid <= 1`, `byte_idx <= 0`.
- `a`, `b`, `a_class`, `b_class` change only on entry to HOLD. They keep the last completed pair through later loads, `clear`, and handshakes.
- HOLD: `byte_valid` is ignored for data and sets `overrun`. An edge with `op_valid & op_ready` clears `op_valid` and returns to LOAD_A.
- `op_ready` is ignored outside HOLD.
- `clear` (any state):
  - State goes to LOAD_A; `sh_a`, `sh_b`, `byte_idx` go to 0.
  - `op_valid` and `overrun` go to 0.
  - `a`/`b`/class outputs are unchanged.
- Priority: `rst` > `clear` > handshake/byte.
  - `clear` with `byte_valid` in the same cycle: the byte is discarded.
  - `clear` with handshake in the same cycle: the result equals `clear`.
- Classification uses exponent e = x[30:23] and mantissa m = x[22:0]:
  - e=FF, m≠0: NaN (11).
  - e=FF, m=0: infinity (10).
  - e=00: zero/subnormal (01).
  - Otherwise: normal (00).
  - The sign bit is ignored.
- Reset values:
  - `a`=0, `b`=0, `a_class`=01, `b_class`=01.
  - `op_valid`=0, `byte_idx`=0, `overrun`=0.
  - `sh_a`=`sh_b`=0; state LOAD_A.

## Timing
- Every output is registered; there is no combinational path from inputs to outputs.
- Byte accept: one per edge where `byte_valid`=1; `byte_idx` is updated the following cycle.
- Latency: 8th byte on edge N → `a`, `b`, classes and `op_valid`=1 are visible after edge N. The `fp_add` sum is valid in that same cycle, because the adder is combinational.
- Handshake on edge H → `op_valid`=0 after H. The earliest next accepted byte is on edge H+1. A byte strobed in the H cycle itself is dropped and sets `overrun`.
- `rst` or `clear` mid-load → the block returns to LOAD_A after that edge; the next byte counts as byte 0.
- Back-to-back strobes every cycle are legal: a pair completes in 8 cycles.

## Test plan
- Load bytes 41 70 00 00 41 A0 00 00 with `MSB_FIRST`=1:
  - `a`=0x41700000, `b`=0x41A00000, both classes 00.
  - `op_valid` rises after the 8th byte's edge.
  - `fp_add` output = 0x420C0000 (35).
- Hold `op_ready`=0 for 5 cycles, then pulse it:
  - `op_valid` stays 1 and `a`/`b` stay stable until the pulse.
  - `op_valid`=0 the cycle after; `a`/`b` are still unchanged.
- Load 5 bytes, assert `clear`, then load a full new pair:
  - `byte_idx` reads 5 and then 0 after `clear`.
  - The old `a`/`b` are kept until the new pair completes correctly.
- With a pair pending, strobe 2 bytes:
  - `overrun`=1 and `a`/`b` are unchanged.
  - After handshake, a new load proceeds; `overrun` is cleared only by `clear`/`rst`.
- Specials: A = 7F C0 00 00, B = 7F 80 00 00 → `a_class`=11, `b_class`=10. Then A = 00 00 00 01, B = 80 00 00 00 → both classes 01.
- Assert `rst` after byte 6: all outputs return to their reset values.
- Instantiate with `MSB_FIRST`=0 and feed bytes 00 00 70 41 00 00 A0 41: `a`=0x41700000, `b`=0x41A00000.
